rem5_serializer: RTL and testbench

- Upstream feeder for the serial divide-by-5 detector.
- Accepts a parallel word (with bit length) over a valid/ready handshake.
- Shifts the word out MSb-first as a valid/sequence bit stream.
- Inserts a guaranteed valid-low gap after each word, so the downstream detector sees a falling edge, emits its flag and returns to remainder 0 before the next word.

---
 rtl/rem5_pkg.sv | 27 ++
 rtl/rem5_ser_cnt.sv | 29 ++
 rtl/rem5_serializer.sv | 162 ++++++++++++++++
 tb/tb_rem5_serializer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/rem5_pkg.sv
// Shared types and constants for the divide-by-5 serial feeder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rem5_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } ser_state_t;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_GAP_CYCLES = 2;

    // Width of a length field able to hold 0..width.
    function automatic int calc_len_w(input int width);
        return $clog2(width + 1);
    endfunction

    // Counter must hold width-1 (bit index) and gap-1 (gap cycles left).
    function automatic int calc_cnt_w(input int width, input int gap);
        int m;
        m = (width > gap) ? width : gap;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/rem5_ser_cnt.sv
// Loadable down-counter with zero flag; shared by the bit and gap phases.
// Latency: load/decrement visible one cycle later; zero flag combinational from count.
// Backpressure: none; decrement saturates at zero.
module rem5_ser_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         zero
);

    // Load takes priority over decrement; hold at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/rem5_serializer.sv
// Parallel-to-serial feeder (MSb first) for the divide-by-5 detector, with a valid-low gap after each word.
// Latency: first bit one cycle after accept; L bits, then GAP_CYCLES idle cycles; optional REM5_SER_TRIM_ZEROS_EN skips leading zeros.
// Backpressure: in_ready high only in IDLE; serial side has no backpressure and a word is never interrupted.
// The serial bit port is named seq and drives the detector's sequence input.
module rem5_serializer
    import rem5_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    // Derived from WIDTH; leave at default.
    parameter int LEN_W      = calc_len_w(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic [LEN_W-1:0] len_in,
    output logic             valid,
    output logic             seq,
    output logic             word_done,
    output logic             busy
);

    localparam int               CNT_W   = calc_cnt_w(WIDTH, GAP_CYCLES);
    localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

    ser_state_t       state;
    logic [WIDTH-1:0] sreg;
    logic [LEN_W-1:0] len_clamp;
    logic [LEN_W-1:0] eff_len;
    logic [WIDTH-1:0] aligned;
    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_load_val;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;

    assign in_ready = (state == ST_IDLE);

    // Zero or oversize lengths mean a full-width word.
    always_comb begin
        len_clamp = ((len_in == '0) || (len_in > WIDTH_L)) ? WIDTH_L : len_in;
    end

`ifdef REM5_SER_TRIM_ZEROS_EN
    logic [WIDTH-1:0] masked;

    // Priority-encode the highest set bit inside the L-bit field; all-zero sends one '0'.
    always_comb begin
        masked  = '0;
        eff_len = LEN_W'(1);
        for (int i = 0; i < WIDTH; i++) begin
            if (i < int'(len_clamp)) begin
                masked[i] = data_in[i];
            end
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (masked[i]) begin
                eff_len = LEN_W'(i + 1);
            end
        end
    end
`else
    // Send exactly L bits, leading zeros included.
    always_comb begin
        eff_len = len_clamp;
    end
`endif

    // Left-align the word so the first bit to send sits in the MSb; upper bits fall off.
    always_comb begin
        aligned = data_in << (WIDTH - int'(eff_len));
    end

    // Counter tracks bits left in SHIFT and gap cycles left in GAP.
    always_comb begin
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = '0;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(int'(eff_len) - 1);
                end
            end
            ST_SHIFT: begin
                if (cnt_zero) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(GAP_CYCLES - 1);
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_GAP: begin
                cnt_dec = !cnt_zero;
            end
            default: begin
                cnt_load = 1'b0;
            end
        endcase
    end

    rem5_ser_cnt #(
        .W(CNT_W)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_load_val),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    // Main FSM with registered stream outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            sreg      <= '0;
            valid     <= 1'b0;
            seq       <= 1'b0;
            word_done <= 1'b0;
            busy      <= 1'b0;
        end else begin
            word_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state <= ST_SHIFT;
                        valid <= 1'b1;
                        seq   <= aligned[WIDTH-1];
                        sreg  <= aligned << 1;
                        busy  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_zero) begin
                        state     <= ST_GAP;
                        valid     <= 1'b0;
                        seq       <= 1'b0;
                        word_done <= 1'b1;
                    end else begin
                        seq  <= sreg[WIDTH-1];
                        sreg <= sreg << 1;
                    end
                end
                ST_GAP: begin
                    if (cnt_zero) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rem5_serializer.sv
// Self-checking bench for rem5_serializer (WIDTH=8, GAP_CYCLES=2).
// Latency: checks first bit at accept+1, L stream cycles, GAP_CYCLES gap cycles, ready after.
// Backpressure: exercises back-to-back accepts with in_valid held high and reset mid-word.
module tb_rem5_serializer;

    localparam int WIDTH = 8;
    localparam int GAP   = 2;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic [LEN_W-1:0] len_in = '0;
    logic             in_ready;
    logic             valid;
    logic             seq;
    logic             word_done;
    logic             busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] d;
        logic [3:0] len;
        int         exp_n;
        logic [7:0] exp_bits;
    } vec_t;

    vec_t vecs[8];

    rem5_serializer #(
        .WIDTH      (WIDTH),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .len_in    (len_in),
        .valid     (valid),
        .seq       (seq),
        .word_done (word_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Observed outputs packed as {valid, seq, word_done, busy, in_ready}.
    function automatic logic [4:0] obs();
        return {valid, seq, word_done, busy, in_ready};
    endfunction

    // Reference: stream is the low L bits of the word (L clamped), optionally without leading zeros.
    function automatic void ref_model(input logic [7:0] d, input logic [3:0] l,
                                      output int n, output logic [7:0] bits);
        int L;
        int v;
        L = ((l == 4'd0) || (l > 4'd8)) ? 8 : int'(l);
        v = int'(d) % (1 << L);
`ifdef REM5_SER_TRIM_ZEROS_EN
        n = (v == 0) ? 1 : $clog2(v + 1);
`else
        n = L;
`endif
        bits = v[7:0];
    endfunction

    // Offer a word; call at a negedge while the DUT is idle.
    task automatic start(input logic [7:0] d, input logic [3:0] l);
        in_valid = 1'b1;
        data_in  = d;
        len_in   = l;
        check("accept_ready", {31'd0, in_ready}, 32'd1);
    endtask

    // Follow one word from its accept edge through the gap to the next idle cycle.
    task automatic stream(input string tag, input int n, input logic [7:0] bits,
                          input bit hold, input logic [7:0] nd, input logic [3:0] nl);
        @(posedge clk);
        #1;
        if (hold) begin
            data_in = nd;
            len_in  = nl;
        end else begin
            in_valid = 1'b0;
            data_in  = 8'($urandom);
            len_in   = 4'($urandom);
        end
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check({tag, "_shift"}, {27'd0, obs()}, {27'd0, 1'b1, bits[n-1-k], 3'b010});
        end
        for (int g = 0; g < GAP; g++) begin
            @(negedge clk);
            check({tag, "_gap"}, {27'd0, obs()}, {27'd0, 2'b00, (g == 0), 2'b10});
        end
        @(negedge clk);
        check({tag, "_idle"}, {27'd0, obs()}, 32'b00001);
    endtask

    initial begin
        int         n;
        int         n2;
        logic [7:0] b;
        logic [7:0] b2;
        logic [7:0] d;
        logic [7:0] nd;
        logic [3:0] l;
        logic [3:0] nl;
        bit         hold;

`ifdef REM5_SER_TRIM_ZEROS_EN
        vecs[0] = '{8'h0A, 4'd8,  4, 8'h0A};
        vecs[1] = '{8'h07, 4'd3,  3, 8'h07};
        vecs[2] = '{8'hA5, 4'd0,  8, 8'hA5};
        vecs[3] = '{8'h3C, 4'd9,  6, 8'h3C};
        vecs[4] = '{8'hF3, 4'd4,  2, 8'h03};
        vecs[5] = '{8'h81, 4'd1,  1, 8'h01};
        vecs[6] = '{8'h00, 4'd8,  1, 8'h00};
        vecs[7] = '{8'hFF, 4'd15, 8, 8'hFF};
`else
        vecs[0] = '{8'h0A, 4'd8,  8, 8'h0A};
        vecs[1] = '{8'h07, 4'd3,  3, 8'h07};
        vecs[2] = '{8'hA5, 4'd0,  8, 8'hA5};
        vecs[3] = '{8'h3C, 4'd9,  8, 8'h3C};
        vecs[4] = '{8'hF3, 4'd4,  4, 8'h03};
        vecs[5] = '{8'h81, 4'd1,  1, 8'h01};
        vecs[6] = '{8'h00, 4'd8,  8, 8'h00};
        vecs[7] = '{8'hFF, 4'd15, 8, 8'hFF};
`endif

        // Reset state
        #1;
        check("reset_state", {27'd0, obs()}, 32'b00001);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_idle", {27'd0, obs()}, 32'b00001);

        // Table-driven words
        for (int i = 0; i < 8; i++) begin
            start(vecs[i].d, vecs[i].len);
            stream($sformatf("vec%0d", i), vecs[i].exp_n, vecs[i].exp_bits, 1'b0, 8'h00, 4'd0);
        end

        // Back-to-back with in_valid held: 0x0F then 0x05
        ref_model(8'h0F, 4'd8, n, b);
        ref_model(8'h05, 4'd8, n2, b2);
        start(8'h0F, 4'd8);
        stream("b2b_a", n, b, 1'b1, 8'h05, 4'd8);
        stream("b2b_b", n2, b2, 1'b0, 8'h00, 4'd0);

        // Reset in the middle of word 0xFF
        start(8'hFF, 4'd8);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_shift", {27'd0, obs()}, 32'b11010);
        #1;
        reset = 1'b1;
        #1;
        check("rst_async", {27'd0, obs()}, 32'b00001);
        repeat (2) begin
            @(negedge clk);
            check("rst_hold", {27'd0, obs()}, 32'b00001);
        end
        reset = 1'b0;
        @(negedge clk);
        check("rst_release", {27'd0, obs()}, 32'b00001);
        ref_model(8'h14, 4'd8, n, b);
        start(8'h14, 4'd8);
        stream("after_rst", n, b, 1'b0, 8'h00, 4'd0);

        // Randomized words, randomly chained back-to-back
        d = 8'($urandom);
        l = 4'($urandom_range(0, 15));
        start(d, l);
        for (int i = 0; i < 40; i++) begin
            ref_model(d, l, n, b);
            hold = (i < 39) && ($urandom_range(0, 1) == 1);
            nd   = 8'($urandom);
            nl   = 4'($urandom_range(0, 15));
            stream("rand", n, b, hold, nd, nl);
            d = nd;
            l = nl;
            if (!hold && (i < 39)) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    check("rand_idle_wait", {27'd0, obs()}, 32'b00001);
                end
                start(d, l);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
